// File: rtl/axi_pkg.sv
// Shared AXI write-address definitions: burst encodings, default field widths
// and the burst legality check used by the AW burst address generator.
package axi_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_BURST_TYPE = 2;
    localparam int AXI_BURST_LEN  = 8;
    localparam int AXI_BEAT_SIZE  = 3;
    localparam int AXI_ID         = 5;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } aw_state_e;

    // Reserved bursts and wraps whose length is not 2/4/8/16 beats are illegal
    function automatic logic burst_is_illegal(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_next_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int BURST_TYPE = AXI_BURST_TYPE,
    parameter int BURST_LEN  = AXI_BURST_LEN,
    parameter int BEAT_SIZE  = AXI_BEAT_SIZE
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BEAT_SIZE-1:0]  size,
    input  logic [BURST_LEN-1:0]  len,
    input  logic [BURST_TYPE-1:0] burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr_s;
    logic [ADDR_WIDTH-1:0] container_s;
    logic [ADDR_WIDTH-1:0] lower_s;
    logic [ADDR_WIDTH-1:0] seq_s;

    assign incr_s      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
    assign container_s = ({{(ADDR_WIDTH-BURST_LEN){1'b0}}, len} + {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) << size;
    assign lower_s     = addr & ~(container_s - {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
    assign seq_s       = addr + incr_s;

    // Select the next address by burst type; anything unexpected steps as INCR
    always_comb begin
        next_addr = seq_s;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = seq_s;
            BURST_WRAP: begin
                if (seq_s == (lower_s + container_s)) begin
                    next_addr = lower_s;
                end else begin
                    next_addr = seq_s;
                end
            end
            default:     next_addr = seq_s;
        endcase
    end

endmodule

// File: rtl/aw_burst_addr_gen.sv
// Accepts one AW command at a time and expands it into per-beat write
// addresses and IDs with valid/ready handshaking on the beat side.
module aw_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int BURST_TYPE = AXI_BURST_TYPE,
    parameter int BURST_LEN  = AXI_BURST_LEN,
    parameter int BEAT_SIZE  = AXI_BEAT_SIZE,
    parameter int ID         = AXI_ID
) (
    input  logic                  AW_burst_clk,
    input  logic                  AW_burst_rst,
    input  logic [ADDR_WIDTH-1:0] in_AWADDR,
    input  logic [BURST_TYPE-1:0] in_AWBURST,
    input  logic [BURST_LEN-1:0]  in_AWLEN,
    input  logic [BEAT_SIZE-1:0]  in_AWSIZE,
    input  logic [ID-1:0]         in_AWID,
    input  logic                  in_AWVALID,
    output logic                  out_AWREADY,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ID-1:0]         beat_id,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic                  beat_last,
    output logic                  busy,
    output logic                  err_illegal
);

    aw_state_e             state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [BURST_TYPE-1:0] burst_r;
    logic [BURST_LEN-1:0]  len_r;
    logic [BEAT_SIZE-1:0]  size_r;
    logic [ID-1:0]         id_r;
    logic [BURST_LEN-1:0]  cnt_r;
    logic                  beat_valid_r;
    logic                  beat_last_r;
    logic                  busy_r;
    logic                  err_r;
    logic                  illegal_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;

    assign illegal_s   = burst_is_illegal(2'(in_AWBURST), 8'(in_AWLEN));
    assign out_AWREADY = (state_r == ST_IDLE) && !AW_burst_rst;
    assign beat_addr   = addr_r;
    assign beat_id     = id_r;
    assign beat_valid  = beat_valid_r;
    assign beat_last   = beat_last_r;
    assign busy        = busy_r;
    assign err_illegal = err_r;

    axi_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_TYPE (BURST_TYPE),
        .BURST_LEN  (BURST_LEN),
        .BEAT_SIZE  (BEAT_SIZE)
    ) u_next_addr (
        .addr      (addr_r),
        .size      (size_r),
        .len       (len_r),
        .burst     (burst_r),
        .next_addr (next_addr_s)
    );

    // Command acceptance, beat sequencing and all registered outputs
    always_ff @(posedge AW_burst_clk) begin
        if (AW_burst_rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            burst_r      <= '0;
            len_r        <= '0;
            size_r       <= '0;
            id_r         <= '0;
            cnt_r        <= '0;
            beat_valid_r <= 1'b0;
            beat_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_AWVALID) begin
                        state_r      <= ST_BURST;
                        addr_r       <= in_AWADDR;
                        // Illegal commands are carried out as INCR
                        burst_r      <= illegal_s ? BURST_TYPE'(BURST_INCR) : in_AWBURST;
                        len_r        <= in_AWLEN;
                        size_r       <= in_AWSIZE;
                        id_r         <= in_AWID;
                        cnt_r        <= '0;
                        beat_valid_r <= 1'b1;
                        beat_last_r  <= (in_AWLEN == '0);
                        busy_r       <= 1'b1;
                        err_r        <= illegal_s;
                    end else begin
                        beat_valid_r <= 1'b0;
                        beat_last_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                ST_BURST: begin
                    err_r <= 1'b0;
                    if (beat_valid_r && beat_ready) begin
                        if (beat_last_r) begin
                            state_r      <= ST_IDLE;
                            beat_valid_r <= 1'b0;
                            beat_last_r  <= 1'b0;
                            busy_r       <= 1'b0;
                        end else begin
                            addr_r      <= next_addr_s;
                            cnt_r       <= cnt_r + {{(BURST_LEN-1){1'b0}}, 1'b1};
                            beat_last_r <= ((cnt_r + {{(BURST_LEN-1){1'b0}}, 1'b1}) == len_r);
                        end
                    end else begin
                        beat_valid_r <= beat_valid_r;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    beat_valid_r <= 1'b0;
                    beat_last_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    err_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aw_burst_addr_gen.sv
// Directed-vector bench for aw_burst_addr_gen: table of bursts plus
// hand-written backpressure and mid-burst reset sequences.
module tb_aw_burst_addr_gen;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [4:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [31:0] beat_addr;
    logic [4:0]  beat_id;
    logic        beat_valid;
    logic        beat_ready;
    logic        beat_last;
    logic        busy;
    logic        err_illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0]      addr;
        logic [1:0]       burst;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [4:0]       id;
        logic             exp_err;
        logic [3:0][31:0] exp_addr;
    } vec_t;

    vec_t vecs [7];

    aw_burst_addr_gen dut (
        .AW_burst_clk (clk),
        .AW_burst_rst (rst),
        .in_AWADDR    (awaddr),
        .in_AWBURST   (awburst),
        .in_AWLEN     (awlen),
        .in_AWSIZE    (awsize),
        .in_AWID      (awid),
        .in_AWVALID   (awvalid),
        .out_AWREADY  (awready),
        .beat_addr    (beat_addr),
        .beat_id      (beat_id),
        .beat_valid   (beat_valid),
        .beat_ready   (beat_ready),
        .beat_last    (beat_last),
        .busy         (busy),
        .err_illegal  (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, need done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one command at a negedge; it is accepted on the following posedge
    task automatic issue(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                         input logic [2:0] s, input logic [4:0] i);
        check("awready_before_cmd", {31'd0, awready}, 32'd1);
        awaddr = a; awburst = b; awlen = l; awsize = s; awid = i; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        n = int'(v.len) + 1;
        beat_ready = 1'b1;
        issue(v.addr, v.burst, v.len, v.size, v.id);
        for (int b = 0; b < n; b++) begin
            check("beat_valid", {31'd0, beat_valid}, 32'd1);
            check("beat_addr", beat_addr, v.exp_addr[b]);
            check("beat_id", {27'd0, beat_id}, {27'd0, v.id});
            check("beat_last", {31'd0, beat_last}, (b == n - 1) ? 32'd1 : 32'd0);
            check("err_illegal", {31'd0, err_illegal}, (b == 0) ? {31'd0, v.exp_err} : 32'd0);
            check("busy", {31'd0, busy}, 32'd1);
            check("awready_in_burst", {31'd0, awready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("idle_beat_valid", {31'd0, beat_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_awready", {31'd0, awready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 2'b01, 8'd3, 3'd2, 5'h01, 1'b0,
                    {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000}};
        vecs[1] = '{32'h0000_1034, 2'b10, 8'd3, 3'd2, 5'h02, 1'b0,
                    {32'h0000_1030, 32'h0000_103C, 32'h0000_1038, 32'h0000_1034}};
        vecs[2] = '{32'h0000_2000, 2'b00, 8'd2, 3'd2, 5'h0A, 1'b0,
                    {32'h0, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000}};
        vecs[3] = '{32'h0000_0100, 2'b10, 8'd2, 3'd0, 5'h03, 1'b1,
                    {32'h0, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100}};
        vecs[4] = '{32'h0000_0040, 2'b11, 8'd1, 3'd1, 5'h1F, 1'b1,
                    {32'h0, 32'h0, 32'h0000_0042, 32'h0000_0040}};
        vecs[5] = '{32'hFFFF_FFFC, 2'b01, 8'd1, 3'd2, 5'h04, 1'b0,
                    {32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC}};
        vecs[6] = '{32'h0000_0018, 2'b10, 8'd1, 3'd3, 5'h05, 1'b0,
                    {32'h0, 32'h0, 32'h0000_0010, 32'h0000_0018}};

        rst = 1'b1; awaddr = 32'd0; awburst = 2'd0; awlen = 8'd0; awsize = 3'd0;
        awid = 5'd0; awvalid = 1'b0; beat_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
        check("rst_beat_last", {31'd0, beat_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        check("rst_beat_addr", beat_addr, 32'd0);
        check("rst_beat_id", {27'd0, beat_id}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
        end

        // Backpressure: INCR from 0, 8-byte beats, stall two cycles on the second beat
        beat_ready = 1'b1;
        issue(32'h0, 2'b01, 8'd3, 3'd3, 5'h06);
        check("bp_beat0", beat_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        beat_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_addr", beat_addr, 32'h8);
            check("bp_hold_valid", {31'd0, beat_valid}, 32'd1);
            check("bp_hold_last", {31'd0, beat_last}, 32'd0);
            if (c < 2) begin
                @(posedge clk);
                @(negedge clk);
            end else begin
                beat_ready = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("bp_beat2", beat_addr, 32'h10);
        check("bp_beat2_last", {31'd0, beat_last}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_beat3", beat_addr, 32'h18);
        check("bp_beat3_last", {31'd0, beat_last}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_done_valid", {31'd0, beat_valid}, 32'd0);

        // Reset in the middle of an 8-beat burst
        issue(32'h0000_0300, 2'b01, 8'd7, 3'd2, 5'h07);
        check("mr_beat0", beat_addr, 32'h0000_0300);
        @(posedge clk);
        @(negedge clk);
        check("mr_beat1", beat_addr, 32'h0000_0304);
        rst = 1'b1;
        #1;
        check("mr_awready_in_rst", {31'd0, awready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("mr_valid_after_rst", {31'd0, beat_valid}, 32'd0);
        check("mr_busy_after_rst", {31'd0, busy}, 32'd0);
        check("mr_addr_after_rst", beat_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_no_resume", {31'd0, beat_valid}, 32'd0);
        check("mr_awready", {31'd0, awready}, 32'd1);
        run_vec('{32'h0000_0500, 2'b01, 8'd1, 3'd0, 5'h08, 1'b0,
                  {32'h0, 32'h0, 32'h0000_0501, 32'h0000_0500}});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aw_burst_addr_gen.md
AW_BURST_ADDR_GEN -- requirements
Module: aw_burst_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AWADDR and beat address width.
REQ-002 SHALL have parameter BURST_TYPE, default 2, meaning AWBURST width.
REQ-003 SHALL have parameter BURST_LEN, default 8, meaning AWLEN width.
REQ-004 SHALL have parameter BEAT_SIZE, default 3, meaning AWSIZE width.
REQ-005 SHALL have parameter ID, default 5, meaning AWID width.
REQ-006 SHALL have port AW_burst_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port AW_burst_rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports in_AWADDR/in_AWBURST/in_AWLEN/in_AWSIZE/in_AWID  input  ADDR_WIDTH/BURST_TYPE/BURST_LEN/BEAT_SIZE/ID  command from the AW FIFO.
REQ-009 SHALL have port in_AWVALID  input  1  command valid.
REQ-010 SHALL have port out_AWREADY  output  1  command accepted when high with in_AWVALID.
REQ-011 SHALL have ports beat_addr  output  ADDR_WIDTH  and beat_id  output  ID  per-beat write address and ID.
REQ-012 SHALL have ports beat_valid  output  1,  beat_ready  input  1,  beat_last  output  1  (final beat).
REQ-013 SHALL have ports busy  output  1  (burst in progress) and err_illegal  output  1  (one-cycle illegal-command pulse).

Function
REQ-014 SHALL implement states IDLE and BURST; IDLE->BURST on in_AWVALID && out_AWREADY; BURST->IDLE on beat handshake with beat_last.
REQ-015 SHALL drive out_AWREADY = (state==IDLE) && !AW_burst_rst; low throughout BURST.
REQ-016 SHALL latch addr, burst, len, size, id on acceptance; command accepted at cycle N gives beat_valid=1 with beat_addr=start address at cycle N+1.
REQ-017 SHALL emit exactly len+1 beats (1..256) using an 8-bit beat counter; beat_last=1 only when counter==len.
REQ-018 SHALL advance address and counter only on beat_valid && beat_ready; all beat outputs hold stable while beat_ready=0.
REQ-019 SHALL, for FIXED (2'b00), repeat the start address for every beat.
REQ-020 SHALL, for INCR (2'b01), add (1<<size) per beat, modulo 2^ADDR_WIDTH.
REQ-021 SHALL, for WRAP (2'b10), use container = (len+1)<<size, lower bound = addr & ~(container-1), and wrap to the lower bound when the next address reaches lower bound + container.
REQ-022 SHALL treat AWBURST=2'b11, or WRAP with len not in {1,3,7,15}, as INCR and pulse err_illegal for one cycle, at cycle N+1.
REQ-023 SHALL drive busy=1 exactly while in BURST.
REQ-024 SHALL return to IDLE after the last handshake, with one idle cycle minimum between bursts; beat_valid=0 in IDLE.

Reset
REQ-025 SHALL, during reset, force state=IDLE, beat_valid=0, beat_last=0, busy=0, err_illegal=0, out_AWREADY=0, and beat_addr/beat_id=0.
REQ-026 SHALL, on reset asserted mid-burst, abandon the burst, with beat_valid=0 on the next edge and no resumption after reset deasserts.

Structure
REQ-027 SHALL take the burst-type encodings FIXED/INCR/WRAP/RSVD and the default widths from shared package axi_pkg.
REQ-028 SHALL place next-address computation in combinational sub-module axi_next_addr (inputs addr, size, len, burst; output next addr).

Verification
REQ-029 SHALL cover INCR: addr 0x1000, len 3, size 2 -> beats 0x1000, 0x1004, 0x1008, 0x100C, beat_last on 4th.
REQ-030 SHALL cover WRAP: addr 0x1034, len 3, size 2 -> 0x1034, 0x1038, 0x103C, 0x1030, beat_last on 4th.
REQ-031 SHALL cover FIXED: addr 0x2000, len 2, id 5'h0A -> 0x2000 three times, beat_id=0x0A throughout.
REQ-032 SHALL cover backpressure: INCR 0x0, len 3, size 3, beat_ready=0 for 2 cycles after beat 2 -> 0x8 held, then 0x10, 0x18.
REQ-033 SHALL cover illegal WRAP len 2: addr 0x100, size 0 -> err_illegal one-cycle pulse, beats 0x100, 0x101, 0x102.
REQ-034 SHALL cover reset mid-burst: reset after beat 1 of len 7 -> beat_valid=0 next cycle, then out_AWREADY=1 after deassert and the next command starts clean.
